// File: rtl/vc_allocator_rr_pkg.sv
// Shared sizing and helper functions for the round-robin VC allocator.
package vc_allocator_rr_pkg;
    localparam int N_OF_REQUEST        = 6;
    localparam int N_BITS_N_OF_REQUEST = 3;
    localparam int N_OF_VN             = 3;
    localparam int N_OF_VC             = 2;
    localparam int N_TOT_OF_VC         = N_OF_VN * N_OF_VC;
    localparam logic [N_BITS_N_OF_REQUEST-1:0] LAST_REQ = N_BITS_N_OF_REQUEST'(N_OF_REQUEST - 1);

    typedef struct packed {
        logic                           found;
        logic [N_BITS_N_OF_REQUEST-1:0] idx;
    } rr_pick_t;

    function automatic int vc_to_vn(input int k);
        return k / N_OF_VC;
    endfunction

    // First set bit scanning upward from ptr, wrapping; reverse loop so the earliest wins.
    function automatic rr_pick_t rr_first(input logic [N_OF_REQUEST-1:0] vec,
                                          input logic [N_BITS_N_OF_REQUEST-1:0] ptr);
        rr_pick_t r;
        int       idx;
        r = '{found: 1'b0, idx: '0};
        for (int i = N_OF_REQUEST - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_OF_REQUEST;
            if (vec[idx]) begin
                r.found = 1'b1;
                r.idx   = idx[N_BITS_N_OF_REQUEST-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [N_OF_VC-1:0] lowest_onehot(input logic [N_OF_VC-1:0] vec);
        logic [N_OF_VC-1:0] oh;
        oh = '0;
        for (int i = N_OF_VC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction
endpackage

// File: rtl/vc_allocator_rr_va_vn_rr.sv
// Per-VN round-robin arbiter: owns the VN pointer, picks winner(s) and their VC.
// VA_MULTI_GRANT_EN allows up to N_OF_VC grants per cycle in this VN.
module va_vn_rr
    import vc_allocator_rr_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_OF_REQUEST-1:0]                elig,
    input  logic [N_OF_REQUEST-1:0][N_OF_VC-1:0]   avail,
    output logic [N_OF_REQUEST-1:0]                grant,
    output logic [N_OF_REQUEST-1:0][N_OF_VC-1:0]   vc_oh
);
    logic [N_BITS_N_OF_REQUEST-1:0] ptr;
    logic [N_BITS_N_OF_REQUEST-1:0] last;
    logic                           any;

`ifdef VA_MULTI_GRANT_EN
    // Greedy walk in round-robin order; each winner claims the lowest VC left unclaimed.
    always_comb begin
        logic [N_OF_VC-1:0] claimed;
        int                 ngr;
        int                 idx;
        grant   = '0;
        vc_oh   = '0;
        any     = 1'b0;
        last    = ptr;
        claimed = '0;
        ngr     = 0;
        idx     = 0;
        for (int i = 0; i < N_OF_REQUEST; i++) begin
            idx = (int'(ptr) + i) % N_OF_REQUEST;
            if (elig[idx] && (|(avail[idx] & ~claimed)) && ngr < N_OF_VC) begin
                grant[idx] = 1'b1;
                vc_oh[idx] = lowest_onehot(avail[idx] & ~claimed);
                claimed    = claimed | vc_oh[idx];
                ngr++;
                any        = 1'b1;
                last       = idx[N_BITS_N_OF_REQUEST-1:0];
            end
        end
    end
`else
    rr_pick_t pick;

    always_comb begin
        pick  = rr_first(elig, ptr);
        grant = '0;
        vc_oh = '0;
        any   = pick.found;
        last  = pick.idx;
        if (pick.found) begin
            grant[pick.idx] = 1'b1;
            vc_oh[pick.idx] = lowest_onehot(avail[pick.idx]);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (any)
            ptr <= (last == LAST_REQ) ? '0 : last + 1'b1;
    end
endmodule

// File: rtl/vc_allocator_rr.sv
// VC allocator top: VN selection, free-VC tracking (alloc_q) and registered grants.
// Define VA_MULTI_GRANT_EN for multiple grants per VN per cycle.
module vc_allocator_rr
    import vc_allocator_rr_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_OF_REQUEST-1:0]               r_va_i,
    input  logic [N_OF_REQUEST*N_TOT_OF_VC-1:0]   r_vc_requested_i,
    output logic [N_OF_REQUEST-1:0]               g_va_o,
    output logic [N_OF_REQUEST*N_TOT_OF_VC-1:0]   g_vc_id_o,
    input  logic [N_TOT_OF_VC-1:0]                release_vc_i,
    input  logic [N_TOT_OF_VC-1:0]                fifo_pointer_state_i,
    output logic [N_TOT_OF_VC-1:0]                vc_allocated_o
);
    logic [N_TOT_OF_VC-1:0]                             alloc_q, alloc_nxt, free;
    logic [N_OF_REQUEST-1:0][N_TOT_OF_VC-1:0]           mask, g_vc_nxt;
    logic [N_OF_REQUEST-1:0]                            g_va_nxt;
    logic [N_OF_VN-1:0][N_OF_REQUEST-1:0]               elig, grant;
    logic [N_OF_VN-1:0][N_OF_REQUEST-1:0][N_OF_VC-1:0]  avail, vc_oh;

    assign mask           = r_vc_requested_i;
    assign free           = ~fifo_pointer_state_i & ~alloc_q;
    assign vc_allocated_o = alloc_q;

    // Each requester competes only in the lowest VN its mask touches.
    always_comb begin
        logic done;
        elig  = '0;
        avail = '0;
        done  = 1'b0;
        for (int j = 0; j < N_OF_REQUEST; j++) begin
            done = 1'b0;
            for (int v = 0; v < N_OF_VN; v++) begin
                if (!done && (|mask[j][v*N_OF_VC +: N_OF_VC])) begin
                    avail[v][j] = mask[j][v*N_OF_VC +: N_OF_VC] & free[v*N_OF_VC +: N_OF_VC];
                    elig[v][j]  = r_va_i[j] & ~g_va_o[j] & (|avail[v][j]);
                    done        = 1'b1;
                end
            end
        end
    end

    for (genvar v = 0; v < N_OF_VN; v++) begin : g_vn
        va_vn_rr u_vn (
            .clk   (clk),
            .rst   (rst),
            .elig  (elig[v]),
            .avail (avail[v]),
            .grant (grant[v]),
            .vc_oh (vc_oh[v])
        );
    end

    always_comb begin
        g_va_nxt  = '0;
        g_vc_nxt  = '0;
        alloc_nxt = alloc_q & ~release_vc_i;
        for (int j = 0; j < N_OF_REQUEST; j++) begin
            for (int v = 0; v < N_OF_VN; v++)
                g_va_nxt[j] = g_va_nxt[j] | grant[v][j];
            for (int k = 0; k < N_TOT_OF_VC; k++)
                g_vc_nxt[j][k] = vc_oh[vc_to_vn(k)][j][k % N_OF_VC];
            alloc_nxt = alloc_nxt | g_vc_nxt[j];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_va_o    <= '0;
            g_vc_id_o <= '0;
            alloc_q   <= '0;
        end else begin
            g_va_o    <= g_va_nxt;
            g_vc_id_o <= g_vc_nxt;
            alloc_q   <= alloc_nxt;
        end
    end
endmodule

// File: doc/vc_allocator_rr.md
Name: vc_allocator_rr

Overview:
Next-generation virtual channel allocator for the NIC injection path. It arbitrates per virtual network (VN) among output-buffer requesters with a rotating round-robin pointer and assigns one free VC per grant. Grants are registered. Allocated VCs are tracked internally until an explicit release, so a VC cannot be handed out twice while its packet is in flight. It sits between the fifo_out buffers and the fifo_nic2noc pointer logic.

Parameters:
N_OF_REQUEST, 6, number of requesters (fifo_out buffers)
N_BITS_N_OF_REQUEST, 3, width of the round-robin pointer (ceil log2 N_OF_REQUEST)
N_OF_VN, 3, number of virtual networks
N_OF_VC, 2, VCs per VN
N_TOT_OF_VC, 6, N_OF_VN*N_OF_VC; VC k belongs to VN k/N_OF_VC

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
r_va_i  in  N_OF_REQUEST  request j wants VA; held until granted
r_vc_requested_i  in  N_OF_REQUEST*N_TOT_OF_VC  acceptable-VC mask per requester, slice j*N_TOT_OF_VC
g_va_o  out  N_OF_REQUEST  registered one-cycle grant pulse
g_vc_id_o  out  N_OF_REQUEST*N_TOT_OF_VC  one-hot granted VC per requester, valid with g_va_o
release_vc_i  in  N_TOT_OF_VC  pulse: VC k tail sent, free it
fifo_pointer_state_i  in  N_TOT_OF_VC  external busy per VC (1 = busy)
vc_allocated_o  out  N_TOT_OF_VC  internal allocation state (alloc_q)

Behaviour:
- Reset (rst low, async): g_va_o=0, g_vc_id_o=0, alloc_q=0, all VN pointers=0.
- free[k] = ~fifo_pointer_state_i[k] & ~alloc_q[k].
- VN selection per requester j: lowest VN v whose mask slice is nonzero; other VNs in the mask are ignored that cycle.
- Eligibility in VN v: r_va_i[j] & (mask_v & free_v)!=0 & ~g_va_o[j]. Masking with g_va_o prevents a double grant during the requester's one-cycle deassert overlap.
- Arbitration: each VN is independent. The winner is the first eligible requester scanning from ptr_v upward, wrapping at N_OF_REQUEST-1 to 0. At most one grant per VN per cycle.
- VC pick: lowest index set in mask_v & free_v.
- Latency: request sampled at edge t; g_va_o[j] and g_vc_id_o slice are high during cycle t+1 only. alloc_q[k] is set at the same edge.
- Pointer update: ptr_v <= winner+1 (mod N_OF_REQUEST) only when VN v grants; otherwise it holds.
- Release: release_vc_i[k] clears alloc_q[k] at the next edge. The VC becomes eligible in the cycle after that edge. Release of an unallocated VC is ignored. Release and allocation of the same k in one cycle cannot occur, since k is not free while allocated.
- fifo_pointer_state_i only masks; it never clears alloc_q.
- Requests dropped before a grant leave no state. Grant outputs are never driven combinationally from inputs.
- Reset mid-operation: all allocations are lost immediately and pending grant pulses are cleared.

Optional Feature:
VA_MULTI_GRANT_EN.
- Defined: each VN issues up to N_OF_VC grants per cycle. Successive round-robin winners take successive lowest free VCs not already claimed that cycle. ptr_v advances past the last winner.
- Undefined: single grant per VN per cycle, as described above.

Decomposition:
- Shared package: N_TOT_OF_VC derivation, VC-to-VN index function, round-robin "first set from pointer" function, lowest-set-bit one-hot function.
- Natural sub-module: va_vn_rr, the per-VN arbiter holding ptr_v and producing winner and VC one-hot. It is instantiated N_OF_VN times.
- alloc_q and the output registers live in the top level.

Test Plan:
- Reset: rst low with all inputs active -> g_va_o=0, g_vc_id_o=0, vc_allocated_o=0, including while rst is held.
- Single request: r_va_i=6'b000001, mask slice0=6'b000011, all free -> next cycle g_va_o=6'b000001, g_vc_id_o[5:0]=6'b000001, vc_allocated_o=6'b000001.
- Exhaustion and release: requesters 1,2,3 request VN1 (mask 6'b001100) -> req1 gets VC2, then req2 gets VC3, req3 waits. Pulse release_vc_i=6'b000100 -> req3 gets VC2 two cycles after the pulse.
- Fairness: requesters 0 and 5 continuously request VN2, with release after each grant -> grants alternate 0,5,0,5 and the pointer wraps 5->0.
- External busy: fifo_pointer_state_i=6'b110000 with VN2 requests -> no grant. Clear bit 4 -> grant of VC4 the next cycle.
- Async reset mid-operation: rst low between grants with vc_allocated_o=6'b001111 -> immediately 0. After reset, the first requester is granted VC0 or VC2 again.
